dco_add_delete: RTL and testbench
=================================

// Module: dco_add_delete
// PURPOSE
//  Digitally controlled oscillator for the ADPLL. It consumes the overflow/underflow
//  pulses from the loop-filter integrator and turns them into phase corrections on the
//  recovered clock.
//  A modulo-DIV_N phase counter normally steps +1 per clk. Each overflow pulse adds one
//  step (the phase advances). Each underflow pulse removes one step (the phase is held).
//  dco_out feeds back to the phase detector that drives the integrator's early input.
// PARAMETERS
//  DIV_N     8   nominal divide ratio clk->dco_out; even, >=4
//  PEND_MAX  3   saturation magnitude of the net pending-correction register
//  (localparams: CW=$clog2(DIV_N); PW=$clog2(PEND_MAX+1)+1)
// PORTS
//  clk          in   1    system clock, rising edge
//  reset        in   1    synchronous, active-low reset (0 = reset)
//  overflow     in   1    1-cycle pulse from integrator: request phase advance
//  underflow    in   1    1-cycle pulse from integrator: request phase retard
//  dco_out      out  1    recovered clock, 50% duty when uncorrected
//  period_tick  out  1    1-cycle pulse, registered, once per dco period
//  pend         out  PW   signed net pending corrections, -PEND_MAX..+PEND_MAX
//  drop         out  1    1-cycle pulse: an incoming request was lost to saturation
// BEHAVIOUR
//  - Reset (reset==0 at posedge) sets the following; all outputs registered:
//    cnt=0, pend=0, corr_done=0, dco_out=0, period_tick=0, drop=0.
//    Reset overrides any pulse present in the same cycle.
//  - Step selection each cycle uses the current pend and corr_done:
//      applied = (pend!=0) && !corr_done
//      step    = applied ? (pend>0 ? 2 : 0) : 1
//  - Counter update: sum = cnt + step; wrap = (sum >= DIV_N); cnt <= wrap ? sum-DIV_N : sum.
//  - dco_out <= (cnt_next < DIV_N/2). period_tick <= wrap.
//    A hold at cnt=DIV_N-1 produces no tick.
//  - Correction rate is at most one per dco period:
//      corr_done <= wrap ? 0 : (corr_done | applied)
//    A correction that itself causes a wrap therefore re-enables correction in the next period.
//  - Pending update: raw = pend + overflow - underflow - (applied ? sign(pend) : 0).
//    Saturate raw to +/-PEND_MAX. drop <= 1 when saturation clipped raw.
//  - overflow and underflow in the same cycle cancel: net 0, no drop.
//  - Latency: a pulse at cycle t is visible in pend at t+1.
//    It is applied no earlier than the step taken at t+1.
//  - Each period therefore lasts DIV_N-1 (advance), DIV_N+1 (retard) or DIV_N clks.
//  - Counter arithmetic is done in CW+1 bits so sum never overflows before the wrap compare.
// TESTING
//  (DIV_N=8, PEND_MAX=3)
//  1. Hold reset=0 for 3 clks with overflow=1.
//     -> cnt=0, pend=0, dco_out=0, period_tick=0, drop=0.
//     Release -> period_tick every 8 clks; dco_out 4 high / 4 low.
//  2. Free-run, then one overflow pulse.
//     -> pend=+1 next clk, then 0; the affected period is 7 clks; later periods 8.
//  3. Free-run, then one underflow pulse.
//     -> pend=-1 then 0; the affected period is 9 clks; no tick lost or doubled.
//  4. overflow=underflow=1 in the same clk.
//     -> pend stays 0, drop=0, every period stays 8 clks.
//  5. overflow held 1 for 5 consecutive clks mid-period.
//     -> pend peaks at +3; drop pulses exactly once.
//     The next 3 periods after the applying period are each 7 clks; then back to 8.
//  6. Build pend=+2, then pulse reset=0 for 1 clk mid-period.
//     -> cnt, pend and corr_done clear; outputs return to reset values.
//     Free-run resumes with 8-clk periods and no stale correction.

Source files
------------

// File: rtl/dco_add_delete.sv
// rtl/dco_add_delete.sv - ADPLL DCO: modulo-DIV_N phase counter with add/delete corrections
// Overflow pulses advance the phase by one step, underflow pulses hold it for one clk.
module dco_add_delete #(
  parameter  int DIV_N    = 8,
  parameter  int PEND_MAX = 3,
  localparam int CW       = $clog2(DIV_N),
  localparam int PW       = $clog2(PEND_MAX + 1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 overflow,
  input  logic                 underflow,
  output logic                 dco_out,
  output logic                 period_tick,
  output logic signed [PW-1:0] pend,
  output logic                 drop
);

  localparam logic [CW:0]          DIV_W = (CW+1)'(DIV_N);
  localparam logic [CW-1:0]        HALF  = CW'(DIV_N / 2);
  localparam logic signed [PW+1:0] ONE   = (PW+2)'(1);
  localparam logic signed [PW+1:0] ZERO  = '0;
  localparam logic signed [PW+1:0] PMAX  = (PW+2)'(PEND_MAX);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0] pend_q, pend_d;
  logic                 corr_done_q, corr_done_d;
  logic                 dco_q, dco_d;
  logic                 tick_q, tick_d;
  logic                 drop_q, drop_d;

  logic                 applied;
  logic [CW:0]          step;
  logic [CW:0]          sum;
  logic                 wrap;
  logic signed [PW+1:0] ext, corr, raw;

  always_comb begin
    applied = (pend_q != '0) && !corr_done_q;
    step    = applied ? (pend_q[PW-1] ? (CW+1)'(0) : (CW+1)'(2)) : (CW+1)'(1);
    sum     = {1'b0, cnt_q} + step;
    wrap    = (sum >= DIV_W);
    cnt_d   = wrap ? CW'(sum - DIV_W) : CW'(sum);
    dco_d   = (cnt_d < HALF);
    tick_d  = wrap;
    corr_done_d = wrap ? 1'b0 : (corr_done_q | applied);

    // A correction walks pend one unit back toward zero.
    ext  = {{2{pend_q[PW-1]}}, pend_q};
    corr = applied ? (pend_q[PW-1] ? ONE : -ONE) : ZERO;
    raw  = ext + $signed({{(PW+1){1'b0}}, overflow})
               - $signed({{(PW+1){1'b0}}, underflow}) + corr;

    pend_d = PW'(raw);
    drop_d = 1'b0;
    if (raw > PMAX) begin
      pend_d = PW'(PMAX);
      drop_d = 1'b1;
    end else if (raw < -PMAX) begin
      pend_d = PW'(-PMAX);
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      corr_done_q <= 1'b0;
      dco_q       <= 1'b0;
      tick_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      corr_done_q <= corr_done_d;
      dco_q       <= dco_d;
      tick_q      <= tick_d;
      drop_q      <= drop_d;
    end
  end

  assign dco_out     = dco_q;
  assign period_tick = tick_q;
  assign pend        = pend_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_dco_add_delete.sv
// tb/tb_dco_add_delete.sv - randomized + directed bench for dco_add_delete against a phase model
module tb_dco_add_delete;

  localparam int DIV_N = 8;
  localparam int PM    = 3;
  localparam int PW    = $clog2(PM + 1) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic overflow = 1'b0;
  logic underflow = 1'b0;
  logic dco_out, period_tick, drop;
  logic signed [PW-1:0] pend;

  always #5 clk = ~clk;

  dco_add_delete #(.DIV_N(DIV_N), .PEND_MAX(PM)) dut (
    .clk(clk), .reset(reset), .overflow(overflow), .underflow(underflow),
    .dco_out(dco_out), .period_tick(period_tick), .pend(pend), .drop(drop)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Phase/pending model: integer phase modulo DIV_N, pending count clamped to +/-PM.
  int m_ph = 0, m_pend = 0;
  bit m_used = 0, m_dco = 0, m_tick = 0, m_drop = 0;

  task automatic model(input bit r, input bit ov, input bit un);
    int stp, nxt, want;
    bit app;
    if (!r) begin
      m_ph = 0; m_pend = 0; m_used = 0; m_dco = 0; m_tick = 0; m_drop = 0;
      return;
    end
    app  = (m_pend != 0) && !m_used;
    stp  = !app ? 1 : (m_pend > 0 ? 2 : 0);
    nxt  = m_ph + stp;
    m_tick = (nxt >= DIV_N);
    m_ph = nxt % DIV_N;
    m_dco = (m_ph < DIV_N / 2);
    m_used = m_tick ? 1'b0 : (m_used | app);
    want = m_pend + int'(ov) - int'(un);
    if (app) want -= (m_pend > 0) ? 1 : -1;
    m_drop = (want > PM) || (want < -PM);
    m_pend = (want > PM) ? PM : (want < -PM) ? -PM : want;
  endtask

  int cyc_n = 0, last_tick = -1, hi_acc = 0, drops = 0, peak = 0, r_cyc = 0;
  int per[$];
  int hiq[$];

  task automatic cyc(input bit r, input bit ov, input bit un);
    reset = r; overflow = ov; underflow = un;
    @(posedge clk);
    model(r, ov, un);
    #1;
    cyc_n++;
    check("dco_out", int'(dco_out), int'(m_dco));
    check("period_tick", int'(period_tick), int'(m_tick));
    check("pend", int'($signed(pend)), m_pend);
    check("drop", int'(drop), int'(m_drop));
    if (dco_out === 1'b1) hi_acc++;
    if (period_tick === 1'b1) begin
      if (last_tick >= 0) begin
        per.push_back(cyc_n - last_tick);
        hiq.push_back(hi_acc);
      end
      last_tick = cyc_n;
      hi_acc = 0;
    end
    if (drop === 1'b1) drops++;
    if (int'($signed(pend)) > peak) peak = int'($signed(pend));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr();
    per.delete(); hiq.delete(); drops = 0; peak = 0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (period_tick === 1'b1) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < 100 && per.size() < n; i++) cyc(1'b1, 1'b0, 1'b0);
    if (per.size() < n) check("period_timeout", per.size(), n);
  endtask

  initial begin
    // 1: reset held with overflow asserted, then free-run
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("t1_pend", int'($signed(pend)), 0);
    check("t1_dco", int'(dco_out), 0);
    check("t1_tick", int'(period_tick), 0);
    check("t1_drop", int'(drop), 0);
    r_cyc = cyc_n;
    wait_tick();
    check("t1_first_tick", cyc_n - r_cyc, 8);
    clr();
    collect(2);
    check("t1_per0", per[0], 8);
    check("t1_per1", per[1], 8);
    check("t1_hi0", hiq[0], 4);
    check("t1_hi1", hiq[1], 4);

    // 2: single overflow -> one 7-clk period
    wait_tick(); clr(); idle(3);
    cyc(1'b1, 1'b1, 1'b0);
    check("t2_pend_a", int'($signed(pend)), 1);
    idle(1);
    check("t2_pend_b", int'($signed(pend)), 0);
    collect(3);
    check("t2_per0", per[0], 7);
    check("t2_per1", per[1], 8);
    check("t2_per2", per[2], 8);

    // 3: single underflow -> one 9-clk period
    wait_tick(); clr(); idle(3);
    cyc(1'b1, 1'b0, 1'b1);
    check("t3_pend_a", int'($signed(pend)), -1);
    idle(1);
    check("t3_pend_b", int'($signed(pend)), 0);
    collect(3);
    check("t3_per0", per[0], 9);
    check("t3_per1", per[1], 8);
    check("t3_per2", per[2], 8);

    // 4: simultaneous pulses cancel
    wait_tick(); clr(); idle(3);
    cyc(1'b1, 1'b1, 1'b1);
    check("t4_pend", int'($signed(pend)), 0);
    check("t4_drop", int'(drop), 0);
    collect(3);
    check("t4_per0", per[0], 8);
    check("t4_per1", per[1], 8);
    check("t4_per2", per[2], 8);

    // 5: five overflows in a row saturate
    wait_tick(); clr(); idle(2);
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    collect(5);
    check("t5_peak", peak, 3);
    check("t5_drops", drops, 1);
    check("t5_per0", per[0], 7);
    check("t5_per1", per[1], 7);
    check("t5_per2", per[2], 7);
    check("t5_per3", per[3], 7);
    check("t5_per4", per[4], 8);

    // 6: reset mid-period discards pending corrections
    wait_tick(); clr(); idle(1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    check("t6_pend_built", int'($signed(pend)), 2);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t6_pend_rst", int'($signed(pend)), 0);
    check("t6_dco_rst", int'(dco_out), 0);
    r_cyc = cyc_n; last_tick = -1; clr();
    wait_tick();
    check("t6_first_tick", cyc_n - r_cyc, 8);
    collect(2);
    check("t6_per0", per[0], 8);
    check("t6_per1", per[1], 8);

    // Random traffic with shifting pulse density and rare resets
    for (int i = 0; i < 3000; i++) begin
      int dens;
      bit r, ov, un;
      dens = 2 + ((i / 500) % 4) * 3;
      r  = ($urandom_range(0, 199) != 0);
      ov = ($urandom_range(0, dens - 1) == 0);
      un = ($urandom_range(0, dens - 1) == 0);
      cyc(r, ov, un);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
